// File: rtl/fp_cvt_int2fp.sv
// fp_cvt_int2fp: iterative 32-bit integer to binary32 converter (FCVT.S.W / FCVT.S.WU).
// Normalizes one bit per cycle, then rounds to nearest even in a single step.
module fp_cvt_int2fp (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data,
  input  logic        i_unsigned,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] mag;
  logic [7:0]  exp;
  logic        sign;
  logic        zero;

  logic signed [31:0] data_s;
  logic               sign_in;
  logic [31:0]        mag_in;
  logic               zero_in;

  // Round-to-nearest-even on a normalized magnitude (bit 31 is the hidden one).
  // A carry out of the fraction leaves the fraction bits at zero and bumps the exponent.
  function automatic logic [31:0] round_pack(input logic s, input logic [7:0] e,
                                             input logic [30:0] m, input logic z);
    logic        up;
    logic [23:0] sum;
    logic [7:0]  e_o;
    up  = m[7] & ((|m[6:0]) | m[8]);
    sum = {1'b0, m[30:8]} + {23'd0, up};
    e_o = sum[23] ? (e + 8'd1) : e;
    if (z) return 32'd0;
    return {s, e_o, sum[22:0]};
  endfunction

  // Any discarded bit set means the result is not exact.
  function automatic logic inexact_of(input logic [7:0] low);
    return |low;
  endfunction

  // Operand decode for the accept cycle: sign and absolute value.
  always_comb begin
    data_s  = $signed(i_data);
    sign_in = ~i_unsigned & i_data[31];
    mag_in  = sign_in ? 32'(-data_s) : i_data;
    zero_in = (mag_in == 32'd0);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; NORM exits when the next shift lands a one in bit 31.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = (zero_in || mag_in[31]) ? ROUND : NORM;
      end
      NORM:    if (mag[30]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, shift-normalize, round and hold the result until handed off.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mag       <= 32'd0;
      exp       <= 8'd0;
      sign      <= 1'b0;
      zero      <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= 32'd0;
      o_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sign <= sign_in;
            mag  <= mag_in;
            exp  <= 8'd158;
            zero <= zero_in;
          end
        end
        NORM: begin
          mag <= {mag[30:0], 1'b0};
          exp <= exp - 8'd1;
        end
        ROUND: begin
          o_data    <= round_pack(sign, exp, mag[30:0], zero);
          o_inexact <= zero ? 1'b0 : inexact_of(mag[7:0]);
          o_valid   <= 1'b1;
        end
        DONE: begin
          if (i_ready) o_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
